// File: rtl/complex_mul_axis.sv
// complex_mul_axis
// Full-precision complex multiplier with AXI-stream handshakes.
// Each of the two slave channels, a and b, has a one-entry operand register.
// When both registers are full and there is result credit, the operands join
// a two-stage product pipeline (P1, P2). P2 writes into a first-word-fall-
// through result FIFO.
//
// Ports
//   aclk, aresetn                 clock, async active-low reset
//   s_axis_a_{tvalid,tready,tdata} operand A = {imag, real}, CW-bit signed each
//   s_axis_b_{tvalid,tready,tdata} operand B, same packing
//   m_axis_dout_{tvalid,tready,tdata} product = {imag, real}, OF-bit signed each
module complex_mul_axis #(
  parameter int CW         = 8,
  parameter int OF         = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              s_axis_a_tvalid,
  output logic              s_axis_a_tready,
  input  logic [2*CW-1:0]   s_axis_a_tdata,
  input  logic              s_axis_b_tvalid,
  output logic              s_axis_b_tready,
  input  logic [2*CW-1:0]   s_axis_b_tdata,
  output logic              m_axis_dout_tvalid,
  input  logic              m_axis_dout_tready,
  output logic [2*OF-1:0]   m_axis_dout_tdata
);

  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNTW:0]   DEPTH_V  = (CNTW + 1)'(FIFO_DEPTH);
  localparam logic [PW-1:0]   LAST_PTR = PW'(FIFO_DEPTH - 1);

  logic                   a_full, b_full;
  logic [2*CW-1:0]        a_reg, b_reg;
  logic signed [CW-1:0]   ar, ai, br, bi;

  logic                   p1_v;
  logic signed [2*CW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic                   p2_v;
  logic [2*OF-1:0]        p2_data;
  logic signed [OF-1:0]   re_w, im_w;

  logic [2*OF-1:0]        mem [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CNTW-1:0]        fifo_count;

  logic [CNTW:0]          occ;
  logic                   do_join, a_hs, b_hs, push, pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Credit counts results already in flight so a push can never hit a full FIFO.
  assign occ     = {1'b0, fifo_count} + (CNTW + 1)'(p1_v) + (CNTW + 1)'(p2_v);
  assign do_join = a_full & b_full & (occ < DEPTH_V);

  // A register can reload in the same cycle its contents leave on a join.
  assign s_axis_a_tready = aresetn & (~a_full | do_join);
  assign s_axis_b_tready = aresetn & (~b_full | do_join);
  assign a_hs = s_axis_a_tvalid & s_axis_a_tready;
  assign b_hs = s_axis_b_tvalid & s_axis_b_tready;

  assign m_axis_dout_tvalid = (fifo_count != '0);
  assign m_axis_dout_tdata  = mem[rd_ptr];
  assign push = p2_v;
  assign pop  = m_axis_dout_tvalid & m_axis_dout_tready;

  assign ar = a_reg[CW-1:0];
  assign ai = a_reg[2*CW-1:CW];
  assign br = b_reg[CW-1:0];
  assign bi = b_reg[2*CW-1:CW];

  // Both sums are exact once the products are sign-extended to OF >= 2*CW+1.
  assign re_w = OF'(p_rr) - OF'(p_ii);
  assign im_w = OF'(p_ri) + OF'(p_ir);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      a_full <= 1'b0;
      b_full <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
    end else begin
      if (a_hs) begin
        a_full <= 1'b1;
        a_reg  <= s_axis_a_tdata;
      end else if (do_join) begin
        a_full <= 1'b0;
      end
      if (b_hs) begin
        b_full <= 1'b1;
        b_reg  <= s_axis_b_tdata;
      end else if (do_join) begin
        b_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      p1_v    <= 1'b0;
      p2_v    <= 1'b0;
      p_rr    <= '0;
      p_ii    <= '0;
      p_ri    <= '0;
      p_ir    <= '0;
      p2_data <= '0;
    end else begin
      p1_v <= do_join;
      p2_v <= p1_v;
      if (do_join) begin
        p_rr <= (2*CW)'(ar) * (2*CW)'(br);
        p_ii <= (2*CW)'(ai) * (2*CW)'(bi);
        p_ri <= (2*CW)'(ar) * (2*CW)'(bi);
        p_ir <= (2*CW)'(ai) * (2*CW)'(br);
      end
      if (p1_v) begin
        p2_data <= {im_w, re_w};
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= p2_data;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNTW'(1);
        2'b01:   fifo_count <= fifo_count - CNTW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_mul_axis.sv
module tb_complex_mul_axis;
  localparam int CW    = 8;
  localparam int OF    = 24;
  localparam int DEPTH = 4;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        a_tvalid = 1'b0, b_tvalid = 1'b0, dout_tready = 1'b0;
  logic [15:0] a_tdata = '0, b_tdata = '0;
  logic        a_tready, b_tready, dout_tvalid;
  logic [47:0] dout_tdata;

  always #5 aclk = ~aclk;

  complex_mul_axis #(.CW(CW), .OF(OF), .FIFO_DEPTH(DEPTH)) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .s_axis_a_tvalid   (a_tvalid),
    .s_axis_a_tready   (a_tready),
    .s_axis_a_tdata    (a_tdata),
    .s_axis_b_tvalid   (b_tvalid),
    .s_axis_b_tready   (b_tready),
    .s_axis_b_tdata    (b_tdata),
    .m_axis_dout_tvalid(dout_tvalid),
    .m_axis_dout_tready(dout_tready),
    .m_axis_dout_tdata (dout_tdata)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [47:0] dout;
  } vec_t;

  vec_t        vecs[8];
  int          checks = 0, failures = 0;
  logic [15:0] aq[$], bq[$], a_src[$], b_src[$];
  logic [47:0] exp_q[$];
  int          a_acc = 0, b_acc = 0, res_cnt = 0;
  bit          abort = 0;
  bit          prev_stall = 0;
  logic [47:0] prev_data = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: plain complex arithmetic on the i-th A paired with the i-th B.
  function automatic logic [47:0] cmul(input logic [15:0] a, input logic [15:0] b);
    int ar, ai, br, bi, re, im;
    ar = int'($signed(a[7:0]));
    ai = int'($signed(a[15:8]));
    br = int'($signed(b[7:0]));
    bi = int'($signed(b[15:8]));
    re = ar * br - ai * bi;
    im = ar * bi + ai * br;
    return {im[23:0], re[23:0]};
  endfunction

  always @(negedge aclk) begin
    if (!aresetn) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", dout_tvalid, 1'b1);
        chk("hold_data", dout_tdata, prev_data);
      end
      if (dut.p2_v) chk("push_not_full", (dut.fifo_count < DEPTH), 1'b1);
      if (a_tvalid && a_tready) begin aq.push_back(a_tdata); a_acc++; end
      if (b_tvalid && b_tready) begin bq.push_back(b_tdata); b_acc++; end
      while (aq.size() > 0 && bq.size() > 0) exp_q.push_back(cmul(aq.pop_front(), bq.pop_front()));
      if (dout_tvalid && dout_tready) begin
        res_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL result_unexpected actual=%0h required=none", dout_tdata);
        end else begin
          chk("result_data", dout_tdata, exp_q.pop_front());
        end
      end
      prev_stall = dout_tvalid && !dout_tready;
      prev_data  = dout_tdata;
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive_a();
    int guard;
    bit hs;
    while (a_src.size() > 0 && !abort) begin
      a_tvalid = 1'b1;
      a_tdata  = a_src[0];
      guard = 0;
      forever begin
        @(negedge aclk);
        hs = a_tready && aresetn;
        @(posedge aclk);
        #1;
        if (hs) begin void'(a_src.pop_front()); break; end
        if (abort) break;
        guard++;
        if (guard > 200) begin
          checks++; failures++;
          $display("FAIL a_drive_timeout actual=stalled required=accepted");
          a_src.delete();
          break;
        end
      end
    end
    a_tvalid = 1'b0;
  endtask

  task automatic drive_b();
    int guard;
    bit hs;
    while (b_src.size() > 0 && !abort) begin
      b_tvalid = 1'b1;
      b_tdata  = b_src[0];
      guard = 0;
      forever begin
        @(negedge aclk);
        hs = b_tready && aresetn;
        @(posedge aclk);
        #1;
        if (hs) begin void'(b_src.pop_front()); break; end
        if (abort) break;
        guard++;
        if (guard > 200) begin
          checks++; failures++;
          $display("FAIL b_drive_timeout actual=stalled required=accepted");
          b_src.delete();
          break;
        end
      end
    end
    b_tvalid = 1'b0;
  endtask

  // Starting just after the handshake edge H: valid only in the cycle after H+3.
  task automatic wait_result(input logic [47:0] exp, input string nm);
    for (int n = 0; n < 5; n++) begin
      @(negedge aclk);
      chk({nm, "_valid"}, dout_tvalid, (n == 3));
      if (n == 3) chk({nm, "_data"}, dout_tdata, exp);
    end
  endtask

  task automatic pair_run(input vec_t v, input string nm);
    step();
    a_tvalid = 1'b1; b_tvalid = 1'b1;
    a_tdata  = v.a;  b_tdata  = v.b;
    @(negedge aclk);
    chk({nm, "_ready"}, {a_tready, b_tready}, 2'b11);
    step();
    a_tvalid = 1'b0; b_tvalid = 1'b0;
    wait_result(v.dout, nm);
  endtask

  task automatic load_random(input int n);
    for (int i = 0; i < n; i++) begin
      a_src.push_back(16'($urandom));
      b_src.push_back(16'($urandom));
    end
  endtask

  task automatic clear_counts();
    a_acc = 0; b_acc = 0; res_cnt = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int run, guard;
    vecs[0] = '{16'h0101, 16'h0101, 48'h000002_000000};
    vecs[1] = '{16'h8080, 16'h8080, 48'h008000_000000};
    vecs[2] = '{16'h7F80, 16'h8080, 48'h000080_007F80};
    vecs[3] = '{16'h0003, 16'h00FE, 48'h000000_FFFFFA};
    vecs[4] = '{16'h7F7F, 16'h7F7F, 48'h007E02_000000};
    vecs[5] = '{16'h0100, 16'h0100, 48'h000000_FFFFFF};
    vecs[6] = '{16'h8000, 16'h0080, 48'h004000_000000};
    vecs[7] = '{16'h0201, 16'h0403, 48'h00000A_FFFFFB};

    // Reset values
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("rst_a_tready", a_tready, 1'b0);
    chk("rst_b_tready", b_tready, 1'b0);
    chk("rst_tvalid", dout_tvalid, 1'b0);
    chk("rst_tdata", dout_tdata, 48'h0);
    @(posedge aclk);
    #3 aresetn = 1'b1;
    @(negedge aclk);
    chk("rel_tready", {a_tready, b_tready}, 2'b11);
    dout_tready = 1'b1;

    // Directed vectors with latency check
    for (int i = 0; i < 8; i++) pair_run(vecs[i], $sformatf("vec%0d", i));

    // Skew: A five cycles ahead of B
    step();
    a_tvalid = 1'b1; a_tdata = vecs[7].a;
    step();
    a_tvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      chk("skew_a_wait", a_tready, 1'b0);
      step();
    end
    b_tvalid = 1'b1; b_tdata = vecs[7].b;
    @(negedge aclk);
    chk("skew_a_wait", a_tready, 1'b0);
    chk("skew_b_ready", b_tready, 1'b1);
    step();
    b_tvalid = 1'b0;
    #3 chk("skew_join_ready", a_tready, 1'b1);
    wait_result(vecs[7].dout, "skew");

    // Backpressure
    step();
    dout_tready = 1'b0;
    clear_counts();
    load_random(10);
    fork drive_a(); drive_b(); join_none
    repeat (20) step();
    chk("bp_a_acc", a_acc, 5);
    chk("bp_b_acc", b_acc, 5);
    chk("bp_treadys", {a_tready, b_tready}, 2'b00);
    chk("bp_tvalid", dout_tvalid, 1'b1);
    dout_tready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      chk("bp_release_valid", dout_tvalid, 1'b1);
    end
    guard = 0;
    while ((res_cnt < 10 || a_src.size() > 0 || b_src.size() > 0) && guard < 100) begin
      step();
      guard++;
    end
    repeat (6) step();
    chk("bp_res_cnt", res_cnt, 10);
    chk("bp_exp_empty", exp_q.size(), 0);

    // Throughput
    clear_counts();
    load_random(16);
    fork drive_a(); drive_b(); join_none
    guard = 0;
    do begin
      @(negedge aclk);
      guard++;
    end while (!dout_tvalid && guard < 30);
    run = dout_tvalid ? 1 : 0;
    guard = 0;
    forever begin
      @(negedge aclk);
      guard++;
      if (!dout_tvalid || guard > 40) break;
      run++;
    end
    chk("tp_run_len", run, 16);
    repeat (4) step();
    chk("tp_res_cnt", res_cnt, 16);
    chk("tp_exp_empty", exp_q.size(), 0);

    // Reset mid-stream with the FIFO full
    step();
    dout_tready = 1'b0;
    clear_counts();
    load_random(10);
    fork drive_a(); drive_b(); join_none
    repeat (20) step();
    chk("mr_pre_tvalid", dout_tvalid, 1'b1);
    abort = 1;
    #2 aresetn = 1'b0;
    #1;
    chk("mr_tvalid", dout_tvalid, 1'b0);
    chk("mr_treadys", {a_tready, b_tready}, 2'b00);
    chk("mr_tdata", dout_tdata, 48'h0);
    aq.delete(); bq.delete(); exp_q.delete();
    a_src.delete(); b_src.delete();
    repeat (3) step();
    abort = 0;
    #2 aresetn = 1'b1;
    @(negedge aclk);
    chk("mr_rel_treadys", {a_tready, b_tready}, 2'b11);
    chk("mr_rel_tvalid", dout_tvalid, 1'b0);
    dout_tready = 1'b1;
    clear_counts();
    pair_run(vecs[2], "mr_fresh");
    repeat (4) step();
    chk("mr_res_cnt", res_cnt, 1);
    chk("final_exp_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/complex_mul_axis.md
# complex_mul_axis

- Synthesizable RTL replacement for the `complex_mul` IP core instantiated by the complex ALU.
- It is the responder on the core's AXI-stream interface:
  - accepts one complex operand on each of the `a` and `b` slave channels;
  - returns their full-precision complex product on the `dout` master channel.
- Adds the ready/backpressure handshakes the IP configuration omits.
- Port names and data packing match the IP, so the ALU can swap cores without editing its datapath.

## Interface
- `CW`, 8: width of each signed operand component; operand word is 2*CW.
- `OF`, 24: width of each output field, ≥ 2*CW+1; output word is 2*OF.
- `FIFO_DEPTH`, 4: result FIFO entries; minimum 4.
- `aclk` in 1: clock; all logic on rising edge.
- `aresetn` in 1: asynchronous, active-low reset.
- `s_axis_a_tvalid` in 1: operand A valid.
- `s_axis_a_tready` out 1: operand A accepted.
- `s_axis_a_tdata` in 2*CW: A = {imag[2CW-1:CW], real[CW-1:0]}, two's complement.
- `s_axis_b_tvalid` in 1: operand B valid.
- `s_axis_b_tready` out 1: operand B accepted.
- `s_axis_b_tdata` in 2*CW: B, same packing as A.
- `m_axis_dout_tvalid` out 1: result valid.
- `m_axis_dout_tready` in 1: downstream accepts result.
- `m_axis_dout_tdata` out 2*OF: result = {imag[2OF-1:OF], real[OF-1:0]}.

## Operation
**Input and join**
- Each slave channel has a one-entry operand register with a full flag: `a_full`, `b_full`.
- A handshake (tvalid & tready) loads the register and sets its flag.
- `occ` = fifo_count + p1_v + p2_v, using registered values only.
- `join` = a_full & b_full & (occ < FIFO_DEPTH), computed combinationally.
- On `join`, both flags clear and the operands move to stage P1.
- `s_axis_x_tready` = aresetn & (!x_full | join).
  - A new operand may load in the same cycle its predecessor leaves.
  - The two channels are independent; either may run ahead by one operand.

**Pipeline**
- Stage P1 registers the four signed products ar*br, ai*bi, ar*bi, ai*br, each 2*CW bits.
- Stage P2 computes:
  - re = ar*br − ai*bi
  - im = ar*bi + ai*br
  - Both are exact at 2*CW+1 bits, sign-extended to OF, and written to the FIFO.
- There is no rounding, saturation or truncation; overflow is impossible by construction.

**Result FIFO**
- First-word-fall-through: `m_axis_dout_tvalid` = (fifo_count != 0); tdata always shows the head entry.
- A pop occurs on tvalid & tready.
- Push and pop in the same cycle leave the count unchanged.
- The occupancy gate guarantees a push never finds the FIFO full; the bench asserts this.
- A pop frees credit only from the next cycle, because `occ` is registered.
- Results are delivered strictly in join order.

**Reset**
- Asserting aresetn low at any time, including mid-transfer, asynchronously clears:
  - a_full, b_full, p1_v, p2_v;
  - the FIFO pointers and count.
- All in-flight and buffered results are discarded.
- Reset values:
  - `s_axis_a_tready` = 0 and `s_axis_b_tready` = 0 while reset is asserted; both go to 1 in the first cycle after release.
  - `m_axis_dout_tvalid` = 0.
  - `m_axis_dout_tdata` = 0, because the FIFO storage is reset.

## Timing
- Latency: if `join` fires at edge E0 and the FIFO is empty, tvalid is high in the cycle after edge E0+2.
  - Counted from the later input handshake at edge H, the result appears after edge H+3.
- Throughput: one result per cycle with both inputs streaming and tready held high. Steady-state `occ` is 3, which is below FIFO_DEPTH.
- Backpressure with tready low:
  - Joins continue until `occ` = FIFO_DEPTH.
  - Each operand register can then hold one more operand, after which both treadys fall.
  - The block holds at most FIFO_DEPTH+1 operand pairs: FIFO_DEPTH results plus one pair in the operand registers.
- A and B arriving in different cycles: the first-arriving operand waits in its register; `join` fires in the cycle after the second handshake.
- Outputs hold while tvalid & !tready (AXI-stream stability rule).

## Test plan
1. Reset, then A=0x0101 and B=0x0101 in the same cycle, dout_tready=1:
   - dout = 0x000002_000000;
   - tvalid high for exactly 1 cycle, 3 cycles after the handshake.
2. Extreme values:
   - A=0x8080, B=0x8080 → dout = 0x008000_000000.
   - A=0x7F80, B=0x8080 → dout = 0x000080_007F80.
3. Skew: A at cycle 0, B at cycle 5:
   - a_tready low from cycle 1 until join;
   - a single result is produced after B's handshake + 3.
4. Backpressure:
   - Hold dout_tready=0 and stream 10 operand pairs → exactly 5 pairs accepted (4 joined, 1 buffered); both treadys then low.
   - Release tready → the 5 results appear in order on 5 consecutive cycles.
   - The remaining 5 pairs then complete with no loss or duplication.
5. Throughput: stream 16 random pairs back-to-back with tready=1 → 16 consecutive valid cycles, each matching a reference model.
6. Reset mid-stream: assert aresetn during case 4 with the FIFO full:
   - tvalid drops to 0 immediately (asynchronously) and treadys are 0;
   - after release, treadys=1;
   - a fresh pair yields only its own result, with no stale data.
